// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes and FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t FIX  = 2'd2;

  // Low op bit clear means the operands are two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One unsigned iteration: right-shift shift-add multiply or left-shift restoring divide.
// Purely combinational; the accumulator holds {hi_part, lo_part} for either operation.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_m,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rs;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_m} : '0);
    w_rs   = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff = w_rs - {1'b0, i_m};
    if (i_is_div) begin
      // Borrow out of the top bit means the trial subtract must be undone.
      if (!w_diff[WIDTH]) o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      else                o_acc = {w_rs[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; result lands WIDTH/STEPS_PER_CYCLE+2 cycles after start.
// busy stalls the pipeline for the whole op; start while busy is dropped, flush aborts.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_neg_q, r_neg_r, r_divz;
  logic               r_busy, r_done;
  logic [WIDTH-1:0]   r_m, r_a, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_last, w_load, w_step, w_commit, w_idle;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_chain [0:STEPS_PER_CYCLE];

  assign w_last = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start && !flush) w_next = RUN;
      RUN:     if (flush) w_next = IDLE;
               else if (w_last) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_idle   = (r_state == IDLE);
    w_load   = w_idle && start && !flush;
    w_step   = (r_state == RUN) && !flush;
    w_commit = (r_state == FIX) && !flush;
  end

  // Iterate on magnitudes; signs are reapplied in FIX.
  always_comb begin
    w_a_neg = op_is_signed(op) & a[WIDTH-1];
    w_b_neg = op_is_signed(op) & b[WIDTH-1];
    w_a_mag = w_a_neg ? -a : a;
    w_b_mag = w_b_neg ? -b : b;
  end

  assign w_chain[0] = r_acc;
  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div (r_is_div),
      .i_acc    (w_chain[g]),
      .i_m      (r_m),
      .o_acc    (w_chain[g+1])
    );
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_divz   <= 1'b0;
      r_m      <= '0;
      r_a      <= '0;
      r_acc    <= '0;
    end else if (w_load) begin
      r_cnt    <= '0;
      r_is_div <= op_is_div(op);
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_divz   <= (b == '0);
      r_a      <= a;
      r_m      <= op_is_div(op) ? w_b_mag : w_a_mag;
      r_acc    <= {{WIDTH{1'b0}}, (op_is_div(op) ? w_a_mag : w_b_mag)};
    end else if (w_step) begin
      r_cnt    <= r_cnt + CW'(1);
      r_acc    <= w_chain[STEPS_PER_CYCLE];
    end
  end

  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_divz) begin
        w_res_lo = '1;
        w_res_hi = r_a;
      end else begin
        w_res_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_res_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= w_commit;
      if (w_commit)            r_hi <= w_res_hi;
      else if (w_idle && hi_we) r_hi <= wdata;
      if (w_commit)            r_lo <= w_res_lo;
      else if (w_idle && lo_we) r_lo <= wdata;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
